// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Arbitration is round-robin. Operands are latched when a request is granted
// and are held on the ALU inputs for EXEC_CYCLES cycles. The ALU result and
// flags are then registered and returned to the winner with a one-cycle done.
// aluop is carried as a plain 4-bit code so this file stands alone; it is
// bit-compatible with the 4-bit cpu_types_pkg opcode enum.
module alu_arbiter #(
   // Cycles the ALU inputs are held before capture; legal range 1..15.
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [1:0]  req,
   input  logic [31:0] portA0,
   input  logic [31:0] portB0,
   input  logic [3:0]  aluop0,
   input  logic [31:0] portA1,
   input  logic [31:0] portB1,
   input  logic [3:0]  aluop1,
   output logic [1:0]  done,
   output logic [31:0] result,
   output logic        neg_flag,
   output logic        over_flag,
   output logic        zero_flag,
   output logic        busy,
   output logic [31:0] alu_portA,
   output logic [31:0] alu_portB,
   output logic [3:0]  alu_aluop,
   input  logic [31:0] alu_outport,
   input  logic        alu_neg,
   input  logic        alu_over,
   input  logic        alu_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter starts at EXEC_CYCLES-1 so that the capture happens in the
   // last of the EXEC_CYCLES execute cycles.
   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [3:0]  op_q, op_d;
   logic        winner_q, winner_d;
   logic        last_grant_q, last_grant_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        neg_q, neg_d;
   logic        over_q, over_d;
   logic        zero_q, zero_d;
   logic        grant_idx;

   // Winner selection: a lone request wins outright; on a tie the requester
   // that was not served last wins.
   always_comb begin
      grant_idx = 1'b0;
      if (req == 2'b11) begin
         grant_idx = ~last_grant_q;
      end else begin
         grant_idx = req[1];
      end
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> EXEC on any request, EXEC -> DONE when the
   // counter runs out, DONE -> IDLE unconditionally.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath next values: latch operands on grant, count down in EXEC,
   // capture the ALU outputs on the final EXEC cycle; hold otherwise.
   always_comb begin
      opa_d        = opa_q;
      opb_d        = opb_q;
      op_d         = op_q;
      winner_d     = winner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      result_d     = result_q;
      neg_d        = neg_q;
      over_d       = over_q;
      zero_d       = zero_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               opa_d        = grant_idx ? portA1 : portA0;
               opb_d        = grant_idx ? portB1 : portB0;
               op_d         = grant_idx ? aluop1 : aluop0;
               winner_d     = grant_idx;
               last_grant_d = grant_idx;
               cnt_d        = CNT_LOAD;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               result_d = alu_outport;
               neg_d    = alu_neg;
               over_d   = alu_over;
               zero_d   = alu_zero;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers; last_grant resets to 1 so requester 0 wins the
   // first tie.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         opa_q        <= '0;
         opb_q        <= '0;
         op_q         <= '0;
         winner_q     <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         result_q     <= '0;
         neg_q        <= 1'b0;
         over_q       <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         op_q         <= op_d;
         winner_q     <= winner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         result_q     <= result_d;
         neg_q        <= neg_d;
         over_q       <= over_d;
         zero_q       <= zero_d;
      end
   end

   // Outputs: done pulses for the winner only in DONE; the ALU is always fed
   // from the operand registers so its inputs never glitch with requester
   // traffic.
   always_comb begin
      done = 2'b00;
      if (state_q == DONE) begin
         done = winner_q ? 2'b10 : 2'b01;
      end
      busy      = (state_q != IDLE);
      alu_portA = opa_q;
      alu_portB = opb_q;
      alu_aluop = op_q;
      result    = result_q;
      neg_flag  = neg_q;
      over_flag = over_q;
      zero_flag = zero_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: two instances (EXEC_CYCLES=1 and 3), each with a
// behavioural ALU attached. Table-driven vectors, hand-written tie/reset/
// stability/withdrawal sequences and a randomized phase checked against a
// transaction-level round-robin model.
module tb_alu_arbiter;

   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd3;
   localparam logic [3:0] ALU_AND = 4'd4;
   localparam logic [3:0] ALU_OR  = 4'd5;
   localparam logic [3:0] ALU_XOR = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd8;

   logic        CLK;
   logic        t_nrst [2];
   logic [1:0]  t_req  [2];
   logic [31:0] t_pa0  [2];
   logic [31:0] t_pb0  [2];
   logic [3:0]  t_op0  [2];
   logic [31:0] t_pa1  [2];
   logic [31:0] t_pb1  [2];
   logic [3:0]  t_op1  [2];
   logic [1:0]  t_done [2];
   logic [31:0] t_res  [2];
   logic        t_neg  [2];
   logic        t_over [2];
   logic        t_zero [2];
   logic        t_busy [2];
   logic [31:0] t_apa  [2];
   logic [31:0] t_apb  [2];
   logic [3:0]  t_aop  [2];
   logic [31:0] t_aout [2];
   logic        t_an   [2];
   logic        t_ao   [2];
   logic        t_az   [2];

   int errors = 0;
   int checks = 0;
   int model_last [2];

   // Behavioural ALU: returns {neg, over, zero, result}.
   function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      logic [31:0] r;
      logic        v;
      r = '0;
      v = 1'b0;
      case (op)
         ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
      return {r[31], v, (r == 32'd0), r};
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [34:0] alu_w;
      assign alu_w      = alu_f(t_apa[gi], t_apb[gi], t_aop[gi]);
      assign t_aout[gi] = alu_w[31:0];
      assign t_az[gi]   = alu_w[32];
      assign t_ao[gi]   = alu_w[33];
      assign t_an[gi]   = alu_w[34];

      alu_arbiter #(.EXEC_CYCLES((gi == 0) ? 1 : 3)) u_dut (
         .CLK         (CLK),
         .nRST        (t_nrst[gi]),
         .req         (t_req[gi]),
         .portA0      (t_pa0[gi]),
         .portB0      (t_pb0[gi]),
         .aluop0      (t_op0[gi]),
         .portA1      (t_pa1[gi]),
         .portB1      (t_pb1[gi]),
         .aluop1      (t_op1[gi]),
         .done        (t_done[gi]),
         .result      (t_res[gi]),
         .neg_flag    (t_neg[gi]),
         .over_flag   (t_over[gi]),
         .zero_flag   (t_zero[gi]),
         .busy        (t_busy[gi]),
         .alu_portA   (t_apa[gi]),
         .alu_portB   (t_apb[gi]),
         .alu_aluop   (t_aop[gi]),
         .alu_outport (t_aout[gi]),
         .alu_neg     (t_an[gi]),
         .alu_over    (t_ao[gi]),
         .alu_zero    (t_az[gi])
      );
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ecyc(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input int k);
      chk("rst_done",  32'(t_done[k]), 32'd0);
      chk("rst_busy",  32'(t_busy[k]), 32'd0);
      chk("rst_result", t_res[k], 32'd0);
      chk("rst_flags", 32'({t_neg[k], t_over[k], t_zero[k]}), 32'd0);
      chk("rst_alu_a", t_apa[k], 32'd0);
      chk("rst_alu_b", t_apb[k], 32'd0);
      chk("rst_alu_op", 32'(t_aop[k]), 32'd0);
   endtask

   // n cycles in which the block must be idle with no done.
   task automatic idle(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk("idle_done", 32'(t_done[k]), 32'd0);
         chk("idle_busy", 32'(t_busy[k]), 32'd0);
      end
   endtask

   // Issue requests given by mask and follow them to completion. The model
   // serves pending requesters in round-robin order; the first grant gives
   // done after E+1 cycles, each following one E+2 cycles after the previous
   // done. Entered and left on a negedge with the block idle.
   task automatic serve(input int k, input logic [1:0] mask,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                        input logic [31:0] er0, input logic [2:0] ef0,
                        input logic [31:0] er1, input logic [2:0] ef1,
                        input bit scramble, input bit withdraw);
      logic [1:0]  pend;
      int          w;
      int          lat;
      bit          gap;
      logic [31:0] sa, sb, er;
      logic [3:0]  so;
      logic [2:0]  ef;
      t_pa0[k] = a0; t_pb0[k] = b0; t_op0[k] = o0;
      t_pa1[k] = a1; t_pb1[k] = b1; t_op1[k] = o1;
      t_req[k] = mask;
      pend = mask;
      gap = 1'b0;
      while (pend != 2'b00) begin
         if (pend == 2'b11) w = (model_last[k] == 0) ? 1 : 0;
         else               w = pend[0] ? 0 : 1;
         model_last[k] = w;
         pend[w] = 1'b0;
         sa = (w == 1) ? a1 : a0;
         sb = (w == 1) ? b1 : b0;
         so = (w == 1) ? o1 : o0;
         er = (w == 1) ? er1 : er0;
         ef = (w == 1) ? ef1 : ef0;
         lat = gap ? ecyc(k) + 2 : ecyc(k) + 1;
         for (int i = 1; i <= lat; i++) begin
            @(negedge CLK);
            if (i < lat) begin
               chk("wait_done", 32'(t_done[k]), 32'd0);
               if (gap && i == 1) begin
                  chk("gap_busy", 32'(t_busy[k]), 32'd0);
               end else begin
                  chk("exec_busy", 32'(t_busy[k]), 32'd1);
                  chk("exec_alu_a", t_apa[k], sa);
                  chk("exec_alu_b", t_apb[k], sb);
                  chk("exec_alu_op", 32'(t_aop[k]), 32'(so));
               end
               if (scramble) begin
                  if (w == 0) begin t_pa0[k] = $urandom; t_pb0[k] = $urandom; t_op0[k] = 4'($urandom); end
                  else        begin t_pa1[k] = $urandom; t_pb1[k] = $urandom; t_op1[k] = 4'($urandom); end
               end
               if (withdraw && i == 1) t_req[k][w] = 1'b0;
            end else begin
               chk("done_bits", 32'(t_done[k]), (w == 1) ? 32'd2 : 32'd1);
               chk("result", t_res[k], er);
               chk("flags_nvz", 32'({t_neg[k], t_over[k], t_zero[k]}), 32'(ef));
               chk("done_busy", 32'(t_busy[k]), 32'd1);
               t_req[k][w] = 1'b0;
            end
            if (!mask[0]) begin t_pa0[k] = $urandom; t_pb0[k] = $urandom; end
            if (!mask[1]) begin t_pa1[k] = $urandom; t_pb1[k] = $urandom; end
         end
         gap = 1'b1;
      end
      idle(k, 1);
   endtask

   typedef struct {
      logic [1:0]  mask;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] exp_r;
      logic [2:0]  exp_f;   // {neg, over, zero}
   } vec_t;

   vec_t vt [8];

   initial begin
      logic [1:0]  m, exp_d;
      logic [31:0] a0, b0, a1, b1;
      logic [3:0]  o0, o1;
      logic [34:0] r0, r1;
      logic [3:0]  oplist [6];

      oplist[0] = ALU_ADD; oplist[1] = ALU_SUB; oplist[2] = ALU_AND;
      oplist[3] = ALU_OR;  oplist[4] = ALU_XOR; oplist[5] = ALU_SLT;

      vt[0] = '{2'b01, 32'd5,          32'd7,          ALU_ADD, 32'd12,         3'b000};
      vt[1] = '{2'b10, 32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  3'b110};
      vt[2] = '{2'b01, 32'd9,          32'd9,          ALU_SUB, 32'd0,          3'b001};
      vt[3] = '{2'b10, 32'd3,          32'd5,          ALU_SUB, 32'hFFFF_FFFE,  3'b100};
      vt[4] = '{2'b01, 32'h8000_0000,  32'd1,          ALU_SUB, 32'h7FFF_FFFF,  3'b010};
      vt[5] = '{2'b10, 32'hFF00_FF00,  32'h0F0F_0F0F,  ALU_AND, 32'h0F00_0F00,  3'b000};
      vt[6] = '{2'b01, 32'hFF00_FF00,  32'h0F0F_0F0F,  ALU_XOR, 32'hF00F_F00F,  3'b100};
      vt[7] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'd0,          3'b001};

      for (int k = 0; k < 2; k++) begin
         t_nrst[k] = 1'b0; t_req[k] = 2'b00;
         t_pa0[k] = '0; t_pb0[k] = '0; t_op0[k] = '0;
         t_pa1[k] = '0; t_pb1[k] = '0; t_op1[k] = '0;
         model_last[k] = 1;
      end

      // Reset values, during and just after reset.
      repeat (3) @(negedge CLK);
      for (int k = 0; k < 2; k++) chk_reset(k);
      for (int k = 0; k < 2; k++) t_nrst[k] = 1'b1;
      @(negedge CLK);
      for (int k = 0; k < 2; k++) chk_reset(k);

      // Continuous tie on the EXEC_CYCLES=1 instance: done order 0, 1, 0.
      t_pa0[0] = 32'd1; t_pb0[0] = 32'd1; t_op0[0] = ALU_ADD;
      t_pa1[0] = 32'd3; t_pb1[0] = 32'd5; t_op1[0] = ALU_SUB;
      t_req[0] = 2'b11;
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLK);
         exp_d = (i == 2 || i == 8) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00;
         chk("tie_done", 32'(t_done[0]), 32'(exp_d));
         if (exp_d == 2'b01) begin
            chk("tie_result0", t_res[0], 32'd2);
            chk("tie_flags0", 32'({t_neg[0], t_over[0], t_zero[0]}), 32'b000);
         end else if (exp_d == 2'b10) begin
            chk("tie_result1", t_res[0], 32'hFFFF_FFFE);
            chk("tie_flags1", 32'({t_neg[0], t_over[0], t_zero[0]}), 32'b100);
         end
      end
      t_req[0] = 2'b00;
      model_last[0] = 0;
      idle(0, 1);

      // Table vectors on both instances.
      for (int k = 0; k < 2; k++) begin
         for (int v = 0; v < 8; v++) begin
            if (vt[v].mask == 2'b01)
               serve(k, 2'b01, vt[v].a, vt[v].b, vt[v].op, $urandom, $urandom, ALU_OR,
                     vt[v].exp_r, vt[v].exp_f, 32'd0, 3'b000, 1'b0, 1'b0);
            else
               serve(k, 2'b10, $urandom, $urandom, ALU_OR, vt[v].a, vt[v].b, vt[v].op,
                     32'd0, 3'b000, vt[v].exp_r, vt[v].exp_f, 1'b0, 1'b0);
         end
      end

      // Operands changed after grant must not affect the EXEC_CYCLES=3 result.
      serve(1, 2'b01, 32'h10, 32'h20, ALU_ADD, 32'd0, 32'd0, ALU_ADD,
            32'h30, 3'b000, 32'd0, 3'b000, 1'b1, 1'b0);
      serve(1, 2'b10, 32'd0, 32'd0, ALU_ADD, 32'd100, 32'd250, ALU_SUB,
            32'd0, 3'b000, 32'hFFFF_FF6A, 3'b100, 1'b1, 1'b0);

      // Request withdrawn during EXEC: done still pulses once, then idle.
      serve(1, 2'b01, 32'd40, 32'd2, ALU_ADD, 32'd0, 32'd0, ALU_ADD,
            32'd42, 3'b000, 32'd0, 3'b000, 1'b0, 1'b1);
      idle(1, 3);

      // Reset in the middle of EXEC.
      t_pa0[1] = 32'd123; t_pb0[1] = 32'd456; t_op0[1] = ALU_ADD;
      t_req[1] = 2'b01;
      repeat (2) @(negedge CLK);
      chk("pre_rst_busy", 32'(t_busy[1]), 32'd1);
      #2;
      t_nrst[1] = 1'b0;
      #1;
      chk_reset(1);
      t_req[1] = 2'b00;
      @(negedge CLK);
      t_nrst[1] = 1'b1;
      model_last[1] = 1;
      idle(1, 5);
      serve(1, 2'b10, 32'd0, 32'd0, ALU_ADD, 32'd77, 32'd23, ALU_ADD,
            32'd0, 3'b000, 32'd100, 3'b000, 1'b0, 1'b0);

      // Randomized operations against the round-robin model.
      for (int n = 0; n < 40; n++) begin
         int k;
         k = n % 2;
         m = 2'($urandom_range(1, 3));
         a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
         a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
         o0 = oplist[$urandom_range(0, 5)];
         o1 = oplist[$urandom_range(0, 5)];
         r0 = alu_f(a0, b0, o0);
         r1 = alu_f(a1, b1, o1);
         serve(k, m, a0, b0, o0, a1, b1, o1,
               r0[31:0], r0[34:32], r1[31:0], r1[34:32], 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
